alu_exec_ctrl: RTL
==================

Name: alu_exec_ctrl

Overview:
- Sequencing front-end for the 8-bit ALU; it is the driving end of the ALU's CS/data_a/data_b/carry_in interface.
- Accepts one register-to-register instruction per valid/ready handshake.
- Reads a 4x8 register file, drives the combinational ALU for one cycle, then captures S, zero and carry_out.
- Writes the result back and maintains the C/Z flag registers, with C fed back as carry_in for addc/subc.

Parameters:
- WIDTH, 8, datapath width; must match the ALU.
- NREGS, 4, register file depth; register index width is 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- instr_valid  input  1  instruction offered
- instr_ready  output  1  block can accept an instruction
- instr  input  8  [7:5] op, [4] unused, [3:2] rd, [1:0] rs
- imm  input  WIDTH  immediate for LDI; sampled with instr
- alu_cs  output  3  ALU operation select
- alu_a  output  WIDTH  ALU data_a = R[rd]
- alu_b  output  WIDTH  ALU data_b = R[rs]
- alu_cin  output  1  ALU carry_in = C flag
- alu_s  input  WIDTH  ALU result
- alu_zero  input  1  ALU zero
- alu_cout  input  1  ALU carry_out
- done  output  1  one-cycle pulse at writeback
- flag_c  output  1  carry flag
- flag_z  output  1  zero flag
- dbg_sel  input  2  register-file read select
- dbg_data  output  WIDTH  R[dbg_sel], combinational

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; R0..R3=0; flag_c=0; flag_z=0; done=0.
  - alu_cs=3'b000; alu_a=0; alu_b=0; alu_cin=0.
  - instr_ready=1 once rst_n releases.
  - Reset mid-instruction abandons it: no writeback, no flag update.
- Opcodes:
  - 000 and, 001 or, 010 add, 011 sub, 100 addc, 101 subc, 110 cmp: ALU ops, alu_cs=op.
  - 111 LDI: no ALU use.
- States:
  - IDLE: instr_ready=1. On instr_valid&instr_ready, latch op/rd/rs/imm.
    - op!=111: load alu_cs=op, alu_a=R[rd], alu_b=R[rs], alu_cin=flag_c (all registered), go to EXEC.
    - op=111: go to WB.
  - EXEC: ALU inputs stable for the full cycle. At end of cycle capture alu_s, alu_zero, alu_cout into internal regs, go to WB.
  - WB: done=1 for exactly this cycle, go to IDLE. Writeback rules:
    - ops 000-101: R[rd]=captured S; flag_z=captured zero.
    - op 010/011: flag_c=captured carry_out.
    - ops 000,001,100,101: flag_c unchanged. The ALU does not drive carry_out for these ops, so that value is never used.
    - op 110 (cmp): no register write; flag_z=captured zero; flag_c unchanged.
    - op 111 (LDI): R[rd]=imm; flag_z=(imm==0); flag_c unchanged.
- instr_ready=0 in EXEC and WB; instr_valid is ignored there.
- Throughput and latency:
  - ALU op: 3 cycles acceptance-to-acceptance; done asserts 2 cycles after acceptance.
  - LDI: 2 cycles; done asserts 1 cycle after acceptance.
- Register updates happen at the WB clock edge.
  - An instruction accepted in the cycle after WB reads the updated register file and flags.
  - No forwarding is needed.
- rd==rs is legal: both operands carry the same value.
- dbg_data shows the pre-write value during the WB cycle and the new value after the edge.
- alu_* outputs hold their last values in IDLE and WB; they change only on acceptance.

Test Plan:
- Reset then LDI R0,8'hF0; LDI R1,8'h20 -> each done 1 cycle after acceptance; dbg R0=F0, R1=20; flag_z=0.
- add R0,R1 (F0+20) -> during EXEC alu_cs=010, alu_a=F0, alu_b=20; after WB R0=10, flag_c=1, flag_z=0.
- addc R1,R1 with C=1 (20+20+1) -> alu_cin=1 in EXEC; R1=41; flag_c stays 1 although alu_cout is forced to 0 by the bench.
- sub with R2=05, R3=07 (sub R2,R3) -> R2=FE, flag_c=0; then LDI R2,0 -> flag_z=1, flag_c=0 unchanged.
- cmp R3,R3 (07 vs 07) -> S=0, flag_z=1, R3 still 07; instr_valid held high throughout -> next instruction accepted exactly 3 cycles later.
- Assert rst_n=0 during EXEC of add -> all registers and flags 0 immediately; done never pulses; instr_ready=1 after release.

Source files
------------

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: sequencing front-end for the 8-bit combinational ALU.
// Accepts one register-to-register instruction per valid/ready handshake,
// reads the 4x8 register file, presents the operands to the ALU for one
// cycle, captures its result and writes back the register file and C/Z flags.
module alu_exec_ctrl #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [7:0]       instr,
  input  logic [WIDTH-1:0] imm,
  output logic [2:0]       alu_cs,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_s,
  input  logic             alu_zero,
  input  logic             alu_cout,
  output logic             done,
  output logic             flag_c,
  output logic             flag_z,
  input  logic [1:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WB
  } state_t;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_ADDC = 3'b100,
    OP_SUBC = 3'b101,
    OP_CMP  = 3'b110,
    OP_LDI  = 3'b111
  } op_t;

  state_t           state;
  op_t              op_q;
  logic [1:0]       rd_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] s_q;
  logic             zero_q;
  logic             cout_q;
  logic [WIDTH-1:0] rf [NREGS];

  op_t        op;
  logic [1:0] rd;
  logic [1:0] rs;
  logic       unused_instr_bit;

  assign op               = op_t'(instr[7:5]);
  assign rd               = instr[3:2];
  assign rs               = instr[1:0];
  assign unused_instr_bit = instr[4];

  // Debug read port: combinational view of the register file.
  assign dbg_data = rf[dbg_sel];

  // Control FSM, ALU operand registers, result capture and writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      instr_ready <= 1'b1;
      done        <= 1'b0;
      flag_c      <= 1'b0;
      flag_z      <= 1'b0;
      alu_cs      <= 3'b000;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_cin     <= 1'b0;
      op_q        <= OP_AND;
      rd_q        <= '0;
      imm_q       <= '0;
      s_q         <= '0;
      zero_q      <= 1'b0;
      cout_q      <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) begin
        rf[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (instr_valid && instr_ready) begin
            op_q        <= op;
            rd_q        <= rd;
            imm_q       <= imm;
            instr_ready <= 1'b0;
            if (op != OP_LDI) begin
              alu_cs  <= op;
              alu_a   <= rf[rd];
              alu_b   <= rf[rs];
              alu_cin <= flag_c;
              state   <= S_EXEC;
            end else begin
              // LDI bypasses the ALU; done is raised for the WB cycle.
              done  <= 1'b1;
              state <= S_WB;
            end
          end
        end

        S_EXEC: begin
          s_q    <= alu_s;
          zero_q <= alu_zero;
          cout_q <= alu_cout;
          done   <= 1'b1;
          state  <= S_WB;
        end

        S_WB: begin
          done        <= 1'b0;
          instr_ready <= 1'b1;
          state       <= S_IDLE;
          case (op_q)
            OP_AND, OP_OR, OP_ADDC, OP_SUBC: begin
              rf[rd_q] <= s_q;
              flag_z   <= zero_q;
            end
            OP_ADD, OP_SUB: begin
              rf[rd_q] <= s_q;
              flag_z   <= zero_q;
              flag_c   <= cout_q;
            end
            OP_CMP: begin
              flag_z <= zero_q;
            end
            OP_LDI: begin
              rf[rd_q] <= imm_q;
              flag_z   <= (imm_q == '0);
            end
            default: begin
            end
          endcase
        end

        default: begin
          state       <= S_IDLE;
          instr_ready <= 1'b1;
          done        <= 1'b0;
        end
      endcase
    end
  end

endmodule
